// File: rtl/std_gray_decoder_pkg.sv
// Shared configuration for the Gray-to-binary decoder slice.
// Latency: n/a (constants only). Backpressure: n/a.
// Holds the default vector width used by the core and the top.
package std_gray_decoder_pkg;

    localparam int unsigned GRAY_DEFAULT_WIDTH = 32;

endpackage : std_gray_decoder_pkg

// File: rtl/std_gray_decoder_core.sv
// Purpose: pure combinational Gray-to-binary decode (prefix XOR from the MSB down).
// Latency: 0 cycles, no clock. Backpressure: none.
// An X on a gray bit spreads to that bit and every lower bit; nothing is masked.
module std_gray_decoder_core
    import std_gray_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    logic acc;

    // Each binary bit is the running XOR of all gray bits at or above it.
    always_comb begin
        acc   = 1'b0;
        o_bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc      = acc ^ i_gray[i];
            o_bin[i] = acc;
        end
    end

endmodule : std_gray_decoder_core

// File: rtl/std_gray_decoder.sv
// Purpose: Gray-to-binary decoder with a combinational output plus a valid-qualified registered copy.
// Latency: o_bin 0 cycles, o_bin_q/o_valid_q 1 cycle. Backpressure: none, every valid sample is taken.
// Optional STD_GRAY_DECODER_STEP_CHECK_EN adds o_step_err / o_step_err_sticky (Hamming step > 1).
module std_gray_decoder
    import std_gray_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_bin_q,
    output logic             o_valid_q
`ifdef STD_GRAY_DECODER_STEP_CHECK_EN
    ,
    output logic             o_step_err,
    output logic             o_step_err_sticky
`endif
);

    std_gray_decoder_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_gray (i_gray),
        .o_bin  (o_bin)
    );

    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] bin_q;
    logic             valid_d;
    logic             valid_q;

    always_comb begin
        bin_d   = bin_q;
        valid_d = i_valid;
        if (i_valid) begin
            bin_d = o_bin;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bin_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            valid_q <= valid_d;
        end
    end

    assign o_bin_q   = bin_q;
    assign o_valid_q = valid_q;

`ifdef STD_GRAY_DECODER_STEP_CHECK_EN
    // More than one bit set iff clearing the lowest set bit leaves something behind.
    function automatic logic multi_bit_diff(input logic [WIDTH-1:0] d);
        return (d & (d - WIDTH'(1))) != '0;
    endfunction

    logic [WIDTH-1:0] last_gray_d;
    logic [WIDTH-1:0] last_gray_q;
    logic             have_ref_d;
    logic             have_ref_q;
    logic             step_err_d;
    logic             step_err_q;
    logic             step_err_sticky_d;
    logic             step_err_sticky_q;

    always_comb begin
        last_gray_d       = last_gray_q;
        have_ref_d        = have_ref_q;
        step_err_d        = 1'b0;
        if (i_valid) begin
            step_err_d  = have_ref_q && multi_bit_diff(i_gray ^ last_gray_q);
            last_gray_d = i_gray;
            have_ref_d  = 1'b1;
        end
        step_err_sticky_d = step_err_sticky_q | step_err_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_gray_q       <= '0;
            have_ref_q        <= 1'b0;
            step_err_q        <= 1'b0;
            step_err_sticky_q <= 1'b0;
        end else begin
            last_gray_q       <= last_gray_d;
            have_ref_q        <= have_ref_d;
            step_err_q        <= step_err_d;
            step_err_sticky_q <= step_err_sticky_d;
        end
    end

    assign o_step_err        = step_err_q;
    assign o_step_err_sticky = step_err_sticky_q;
`endif

endmodule : std_gray_decoder

// File: tb/tb_std_gray_decoder.sv
// Self-checking bench for std_gray_decoder at WIDTH=16 and WIDTH=1 against a behavioural model.
module tb_std_gray_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [15:0] gray16;
    logic [15:0] bin16;
    logic [15:0] bin_q16;
    logic        valid_q16;
    logic [0:0]  gray1;
    logic [0:0]  bin1;
    logic [0:0]  bin_q1;
    logic        valid_q1;
`ifdef STD_GRAY_DECODER_STEP_CHECK_EN
    logic        step_err;
    logic        step_err_sticky;
    logic        step_err1;
    logic        step_err_sticky1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    std_gray_decoder #(.WIDTH(16)) dut16 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_gray    (gray16),
        .o_bin     (bin16),
        .i_valid   (valid),
        .o_bin_q   (bin_q16),
        .o_valid_q (valid_q16)
`ifdef STD_GRAY_DECODER_STEP_CHECK_EN
        ,
        .o_step_err        (step_err),
        .o_step_err_sticky (step_err_sticky)
`endif
    );

    std_gray_decoder #(.WIDTH(1)) dut1 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_gray    (gray1),
        .o_bin     (bin1),
        .i_valid   (valid),
        .o_bin_q   (bin_q1),
        .o_valid_q (valid_q1)
`ifdef STD_GRAY_DECODER_STEP_CHECK_EN
        ,
        .o_step_err        (step_err1),
        .o_step_err_sticky (step_err_sticky1)
`endif
    );

    // Reference state for the registered outputs.
    logic [15:0] m_bq16;
    logic        m_vq16;
    logic        m_bq1;
    logic        m_vq1;
    logic        m_have;
    logic [15:0] m_last;
    logic        m_err;
    logic        m_sticky;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Decode as the XOR of all right-shifts of the gray word.
    function automatic logic [15:0] ref_dec(input logic [15:0] g);
        logic [15:0] r = '0;
        for (int k = 0; k < 16; k++) r ^= (g >> k);
        return r;
    endfunction

    function automatic logic [15:0] ref_enc(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_bq16 = '0; m_vq16 = 1'b0; m_bq1 = 1'b0; m_vq1 = 1'b0;
            m_have = 1'b0; m_last = '0; m_err = 1'b0; m_sticky = 1'b0;
        end else begin
            m_vq16 = valid;
            m_vq1  = valid;
            m_err  = valid && m_have && ($countones(gray16 ^ m_last) > 1);
            m_sticky = m_sticky | m_err;
            if (valid) begin
                m_bq16 = ref_dec(gray16);
                m_bq1  = gray1[0];
                m_last = gray16;
                m_have = 1'b1;
            end
        end
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, ".bin_q16"},   32'(bin_q16),   32'(m_bq16));
        check_eq({tag, ".valid_q16"}, 32'(valid_q16), 32'(m_vq16));
        check_eq({tag, ".bin_q1"},    32'(bin_q1),    32'(m_bq1));
        check_eq({tag, ".valid_q1"},  32'(valid_q1),  32'(m_vq1));
`ifdef STD_GRAY_DECODER_STEP_CHECK_EN
        check_eq({tag, ".step_err"},    32'(step_err),        32'(m_err));
        check_eq({tag, ".step_sticky"}, 32'(step_err_sticky), 32'(m_sticky));
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_regs(tag);
    endtask

    logic [15:0] spot_g [5] = '{16'h0001, 16'h0003, 16'h8000, 16'hC000, 16'h0000};
    logic [15:0] spot_b [5] = '{16'h0001, 16'h0002, 16'hFFFF, 16'h8000, 16'h0000};

    initial begin
        rst_n  = 1'b0;
        valid  = 1'b1;
        gray16 = 16'h8000;
        gray1  = 1'b1;

        // Reset held for two edges with valid high.
        #1;
        tick("rst0");
        tick("rst1");
        check_eq("rst.bin_q16",   32'(bin_q16),   32'h0);
        check_eq("rst.valid_q16", 32'(valid_q16), 32'h0);
        check_eq("rst.bin16",     32'(bin16),     32'hFFFF);

        rst_n = 1'b1;
        tick("rel");
        check_eq("rel.bin_q16",   32'(bin_q16),   32'hFFFF);
        check_eq("rel.valid_q16", 32'(valid_q16), 32'h1);

        // Valid gating: captured value holds while valid is low.
        gray16 = 16'h0003;
        tick("gate1");
        check_eq("gate1.bin_q16", 32'(bin_q16), 32'h0002);
        valid  = 1'b0;
        gray16 = 16'h8000;
        tick("gate2");
        check_eq("gate2.bin_q16",   32'(bin_q16),   32'h0002);
        check_eq("gate2.valid_q16", 32'(valid_q16), 32'h0);
        check_eq("gate2.bin16",     32'(bin16),     32'hFFFF);
        tick("gate3");
        check_eq("gate3.bin_q16", 32'(bin_q16), 32'h0002);

        for (int i = 0; i < 5; i++) begin
            gray16 = spot_g[i];
            #1;
            check_eq($sformatf("spot%0d", i), 32'(bin16), 32'(spot_b[i]));
        end

        gray1 = 1'b0;
        #1;
        check_eq("w1.g0", 32'(bin1), 32'h0);
        gray1 = 1'b1;
        #1;
        check_eq("w1.g1", 32'(bin1), 32'h1);

        // Exhaustive round trip; valid is low so the registered state is unaffected.
        for (int b = 0; b < 65536; b++) begin
            gray16 = ref_enc(16'(b));
            #1;
            check_eq("sweep.inv", 32'(bin16), 32'(b));
            check_eq("sweep.ref", 32'(bin16), 32'(ref_dec(gray16)));
        end
        @(posedge clk);
        #1;
        check_regs("resync");

`ifdef STD_GRAY_DECODER_STEP_CHECK_EN
        rst_n = 1'b0;
        tick("sc.rst");
        rst_n = 1'b1;
        valid = 1'b1;
        gray16 = 16'h0000; tick("sc.s0");
        check_eq("sc.first", 32'(step_err), 32'h0);
        gray16 = 16'h0001; tick("sc.s1");
        gray16 = 16'h0001; tick("sc.s2");
        check_eq("sc.hold", 32'(step_err), 32'h0);
        gray16 = 16'h0002; tick("sc.s3");
        check_eq("sc.pulse", 32'(step_err), 32'h1);
        valid = 1'b0;
        tick("sc.after");
        check_eq("sc.after_err",    32'(step_err),        32'h0);
        check_eq("sc.after_sticky", 32'(step_err_sticky), 32'h1);
`endif

        // Randomized traffic: occasional reset, random valid, mix of single-bit steps and jumps.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 24) != 0);
            valid = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 2) == 0)
                gray16 = 16'($urandom);
            else if ($urandom_range(0, 1) == 1)
                gray16 = gray16 ^ (16'h1 << $urandom_range(0, 15));
            gray1 = 1'($urandom_range(0, 1));
            #1;
            check_eq("rand.bin16", 32'(bin16), 32'(ref_dec(gray16)));
            check_eq("rand.bin1",  32'(bin1),  32'(gray1));
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_std_gray_decoder
